// File: rtl/add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// add_sequencer_pkg
// Shared definitions for the multi-precision add/subtract sequencer:
//   - state_t : FSM state encoding (ST_IDLE, ST_RUN, ST_DONE), 2 bits wide
//   - SLICE_W : width of one adder slice (the shared full_adder16)
// No ports.
// ---------------------------------------------------------------------------
package add_sequencer_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/add_sequencer_if.sv
// ---------------------------------------------------------------------------
// add_sequencer_if
// Request/response bundle between the ALU control logic (master) and the
// add_sequencer (slave).
//   master -> slave : start, sub, a[W-1:0], b[W-1:0]
//   slave -> master : ready, busy, done, result[W-1:0], cout, ovf
// W = SLICE_W * WORDS.
// ---------------------------------------------------------------------------
import add_sequencer_pkg::*;

interface add_sequencer_if #(
   parameter int WORDS = 4
);
   localparam int W = SLICE_W * WORDS;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   modport master (
      output start, sub, a, b,
      input  ready, busy, done, result, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output ready, busy, done, result, cout, ovf
   );

endinterface

// File: rtl/add_sequencer_full_adder16.sv
// ---------------------------------------------------------------------------
// full_adder16
// 16-bit binary adder slice with carry in and carry out.
//   a[15:0], b[15:0] : addends
//   cin              : carry in
//   sum[15:0]        : a + b + cin, modulo 2^16
//   cout             : carry out of bit 15
// ---------------------------------------------------------------------------
module full_adder16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [16:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {16'd0, cin};
   assign sum   = total[15:0];
   assign cout  = total[16];

endmodule

// File: rtl/add_sequencer.sv
// ---------------------------------------------------------------------------
// add_sequencer
// Multi-precision add/subtract controller. One shared full_adder16 is stepped
// over WORDS 16-bit slices, least significant slice first, with the carry
// held in a register between slices. Trades latency for adder area.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset; aborts any operation in flight
//   bus  : add_sequencer_if.slave
//            start/sub/a/b     request, sampled only while ready=1
//            ready             high in IDLE
//            busy              high in RUN
//            done              one-cycle pulse, result/cout/ovf valid from here
//            result/cout/ovf   W-bit sum or difference, carry (1 = no borrow
//                              when subtracting), signed overflow
// Latency: accept on edge E0, slices on E1..E_WORDS, done in the following
// cycle, back to IDLE one cycle later.
// ---------------------------------------------------------------------------
import add_sequencer_pkg::*;

module add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic            clk,
   input  logic            rst,
   add_sequencer_if.slave  bus
);

   localparam int W     = SLICE_W * WORDS;
   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic               sub_q;
   logic [W-1:0]       result_q;
   logic               cout_q;
   logic               ovf_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;

   logic [SLICE_W-1:0] a_sl;
   logic [SLICE_W-1:0] b_sl;
   logic [SLICE_W-1:0] sum_sl;
   logic               cout_sl;

   // Two's complement overflow: like-signed inputs giving an opposite-signed sum.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   // Slice mux; subtraction is a + ~b + 1, the +1 coming from carry seeded with sub.
   assign a_sl = a_q[idx * SLICE_W +: SLICE_W];
   assign b_sl = b_q[idx * SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};

   full_adder16 u_adder (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry),
      .sum  (sum_sl),
      .cout (cout_sl)
   );

   // Operand capture: pure data, only loaded on an accepted start.
   always_ff @(posedge clk) begin
      if (!rst && state == ST_IDLE && bus.start) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         sub_q <= bus.sub;
      end
   end

   // Control FSM with registered handshake outputs and result demux.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  idx      <= '0;
                  carry    <= bus.sub;
                  result_q <= '0;
                  cout_q   <= 1'b0;
                  ovf_q    <= 1'b0;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state    <= ST_RUN;
               end
            end

            ST_RUN: begin
               result_q[idx * SLICE_W +: SLICE_W] <= sum_sl;
               carry <= cout_sl;
               if (idx == LAST_IDX) begin
                  // idx parks at 0 so it never runs past the last slice.
                  idx    <= '0;
                  cout_q <= cout_sl;
                  ovf_q  <= signed_ovf(a_sl[SLICE_W-1], b_sl[SLICE_W-1],
                                       sum_sl[SLICE_W-1]);
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            ST_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end

            default: begin
               idx     <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready  = ready_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
   assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_add_sequencer
// Self-checking bench for add_sequencer with WORDS=4 (64-bit operands):
// directed vector table, handshake and mid-operation reset sequences, and
// random operations compared against a signed/unsigned arithmetic model.
// ---------------------------------------------------------------------------
module tb_add_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic clk;
   logic rst;

   int checks;
   int errors;

   add_sequencer_if #(.WORDS(WORDS)) bus ();

   add_sequencer #(.WORDS(WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] exp_result;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference: signed result range decides overflow, unsigned compare/sum
   // decides carry; result is the value modulo 2^W.
   function automatic logic [W+1:0] ref_model(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic s);
      logic signed [W+1:0] sx, sy, sr;
      logic [W:0]          usum;
      logic                c, o;
      sx = {{2{x[W-1]}}, x};
      sy = {{2{y[W-1]}}, y};
      sr = s ? (sx - sy) : (sx + sy);
      o  = (sr[W+1:W-1] != 3'b000) && (sr[W+1:W-1] != 3'b111);
      usum = {1'b0, x} + {1'b0, y};
      c  = s ? (x >= y) : usum[W];
      return {o, c, sr[W-1:0]};
   endfunction

   // Starts an operation from IDLE (called just after a rising edge) and
   // returns the edges from accept to done, plus the outputs seen at done.
   task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic os, output int lat,
                        output logic [W-1:0] r, output logic c, output logic o);
      bus.a     = oa;
      bus.b     = ob;
      bus.sub   = os;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      // Scramble the pins to show operands were captured at accept.
      bus.a     = ~oa;
      bus.b     = ~ob;
      bus.sub   = ~os;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      r = bus.result;
      c = bus.cout;
      o = bus.ovf;
      @(posedge clk); #1;
   endtask

   initial begin
      int             lat;
      int             done_cnt;
      logic [W-1:0]   r;
      logic           c, o;
      logic [W+1:0]   m;
      logic [W-1:0]   ra, rb;
      logic           rs;

      checks = 0;
      errors = 0;

      vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
      vecs[2] = '{64'h3, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[3] = '{64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0};
      vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[6] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
      vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",  W'(bus.ready), W'(1));
      check("rst_busy",   W'(bus.busy),  W'(0));
      check("rst_done",   W'(bus.done),  W'(0));
      check("rst_result", bus.result,    '0);
      check("rst_cout",   W'(bus.cout),  W'(0));
      check("rst_ovf",    W'(bus.ovf),   W'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat, r, c, o);
         check($sformatf("vec%0d_latency", i), W'(lat), W'(WORDS));
         check($sformatf("vec%0d_result", i),  r,       vecs[i].exp_result);
         check($sformatf("vec%0d_cout", i),    W'(c),   W'(vecs[i].exp_cout));
         check($sformatf("vec%0d_ovf", i),     W'(o),   W'(vecs[i].exp_ovf));
         check($sformatf("vec%0d_done_pulse", i), W'(bus.done),  W'(0));
         check($sformatf("vec%0d_ready", i),      W'(bus.ready), W'(1));
         check($sformatf("vec%0d_held", i),       bus.result,    vecs[i].exp_result);
      end

      // Handshake: start during RUN and DONE is ignored, start right after is taken
      bus.a = 64'h5; bus.b = 64'h3; bus.sub = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      check("hs_accept_busy", W'(bus.busy), W'(1));
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.a = 64'h1234; bus.b = 64'h1111; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = -1;
      for (int k = 3; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      check("hs_latency",  W'(lat),    W'(WORDS));
      check("hs_result",   bus.result, 64'h2);
      check("hs_cout",     W'(bus.cout), W'(1));
      // DONE cycle: a start here must be dropped
      bus.a = 64'hAAAA; bus.b = 64'h1; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      check("hs_done_ignored_ready", W'(bus.ready), W'(1));
      check("hs_done_ignored_result", bus.result, 64'h2);
      // Cycle after done: accepted
      bus.a = 64'h10; bus.b = 64'h20; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("hs_after_ready", W'(bus.ready), W'(0));
      check("hs_after_busy",  W'(bus.busy),  W'(1));
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      check("hs_after_latency", W'(lat), W'(WORDS));
      check("hs_after_result",  bus.result, 64'h30);
      @(posedge clk); #1;

      // Reset during the second RUN cycle
      bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'h1; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstmid_ready",  W'(bus.ready), W'(1));
      check("rstmid_busy",   W'(bus.busy),  W'(0));
      check("rstmid_done",   W'(bus.done),  W'(0));
      check("rstmid_result", bus.result,    '0);
      done_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.done) done_cnt++;
         @(posedge clk); #1;
      end
      check("rstmid_no_done", W'(done_cnt), W'(0));
      do_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, lat, r, c, o);
      check("rstmid_next_latency", W'(lat), W'(WORDS));
      check("rstmid_next_result",  r, 64'h1234_5678_9ABC_DF00);

      // Random operations against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: ra = {1'b0, {(W-1){1'b1}}};
            1: rb = {1'b1, {(W-1){1'b0}}};
            2: rb = ra;
            default: ;
         endcase
         m = ref_model(ra, rb, rs);
         do_op(ra, rb, rs, lat, r, c, o);
         check($sformatf("rnd%0d_result", i), r,     m[W-1:0]);
         check($sformatf("rnd%0d_cout", i),   W'(c), W'(m[W]));
         check($sformatf("rnd%0d_ovf", i),    W'(o), W'(m[W+1]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
